// File: rtl/sha_1_stream.sv
// SHA-1 block engine. Chaining values carry across 512-bit blocks and the digest is emitted after the block flagged last.
// Valid/ready handshakes on both sides; ROUNDS_PER_CYCLE compression rounds are unrolled per clock.
module sha_1_stream #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int CNT_W            = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             blk_valid,
  output logic             blk_ready,
  input  logic             blk_first,
  input  logic             blk_last,
  input  logic [31:0]      blk_data [15:0],
  input  logic             abort,
  output logic             digest_valid,
  input  logic             digest_ready,
  output logic [31:0]      digest [4:0],
  output logic [CNT_W-1:0] blk_count,
  output logic             busy
);
  localparam int N  = 80 / ROUNDS_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [4:0][31:0] H_INIT = {32'hC3D2E1F0, 32'h10325476, 32'h98BADCFE,
                                         32'hEFCDAB89, 32'h67452301};

  if (ROUNDS_PER_CYCLE < 1 || ROUNDS_PER_CYCLE > 80 || (80 % ROUNDS_PER_CYCLE) != 0) begin : g_bad_rpc
    $error("sha_1_stream: ROUNDS_PER_CYCLE must divide 80");
  end

  typedef enum logic [1:0] {IDLE, ROUND, UPDATE, OUT} state_t;

  state_t             state_reg, state_next;
  logic               started_reg;
  logic [15:0][31:0]  win_reg;
  logic [4:0][31:0]   wk_reg;
  logic [4:0][31:0]   h_reg;
  logic [4:0][31:0]   digest_reg;
  logic [4:0][31:0]   h_sum;
  logic               last_reg;
  logic [CW-1:0]      cnt_reg;
  logic [CNT_W-1:0]   count_reg;
  logic               accept;

  logic [15:0][31:0]  w_c;
  logic [4:0][31:0]   s_c;
  logic [6:0]         t_c;
  logic [31:0]        f_c, k_c, x_c, temp_c;

  // started_reg holds blk_ready low until the first edge after reset release.
  assign blk_ready    = started_reg && (state_reg == IDLE);
  assign accept       = blk_valid && blk_ready && !abort;
  assign digest_valid = (state_reg == OUT);
  assign busy         = (state_reg != IDLE);
  assign blk_count    = count_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_word
      assign h_sum[gi]  = h_reg[gi] + wk_reg[gi];
      assign digest[gi] = digest_reg[gi];
    end
  endgenerate

  // Unrolled rounds; s_c[0..4] = a..e, w_c[0] is the word consumed by the current round.
  always_comb begin
    w_c    = win_reg;
    s_c    = wk_reg;
    t_c    = '0;
    f_c    = '0;
    k_c    = '0;
    x_c    = '0;
    temp_c = '0;
    for (int r = 0; r < ROUNDS_PER_CYCLE; r++) begin
      t_c = 7'(cnt_reg) * 7'(ROUNDS_PER_CYCLE) + 7'(r);
      if (t_c < 7'd20) begin
        f_c = (s_c[1] & s_c[2]) | (~s_c[1] & s_c[3]);
        k_c = 32'h5A827999;
      end else if (t_c < 7'd40) begin
        f_c = s_c[1] ^ s_c[2] ^ s_c[3];
        k_c = 32'h6ED9EBA1;
      end else if (t_c < 7'd60) begin
        f_c = (s_c[1] & s_c[2]) | (s_c[1] & s_c[3]) | (s_c[2] & s_c[3]);
        k_c = 32'h8F1BBCDC;
      end else begin
        f_c = s_c[1] ^ s_c[2] ^ s_c[3];
        k_c = 32'hCA62C1D6;
      end
      temp_c = {s_c[0][26:0], s_c[0][31:27]} + f_c + s_c[4] + k_c + w_c[0];
      x_c    = w_c[13] ^ w_c[8] ^ w_c[2] ^ w_c[0];
      w_c    = {x_c[30:0], x_c[31], w_c[15:1]};
      s_c    = {s_c[3], s_c[2], {s_c[1][1:0], s_c[1][31:2]}, s_c[0], temp_c};
    end
  end

  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (accept) state_next = ROUND;
        ROUND:   if (cnt_reg == CW'(N - 1)) state_next = UPDATE;
        UPDATE:  state_next = last_reg ? OUT : IDLE;
        OUT:     if (digest_ready) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      started_reg <= 1'b0;
      win_reg     <= '0;
      wk_reg      <= '0;
      h_reg       <= H_INIT;
      digest_reg  <= '0;
      last_reg    <= 1'b0;
      cnt_reg     <= '0;
      count_reg   <= '0;
    end else begin
      started_reg <= 1'b1;
      if (abort) begin
        h_reg     <= H_INIT;
        count_reg <= '0;
        cnt_reg   <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (accept) begin
              for (int j = 0; j < 16; j++) win_reg[j] <= blk_data[j];
              wk_reg   <= blk_first ? H_INIT : h_reg;
              last_reg <= blk_last;
              cnt_reg  <= '0;
              if (blk_first) begin
                h_reg     <= H_INIT;
                count_reg <= '0;
              end
            end
          end
          ROUND: begin
            win_reg <= w_c;
            wk_reg  <= s_c;
            cnt_reg <= (cnt_reg == CW'(N - 1)) ? '0 : cnt_reg + 1'b1;
          end
          UPDATE: begin
            h_reg <= h_sum;
            if (count_reg != '1) count_reg <= count_reg + 1'b1;
            if (last_reg) digest_reg <= h_sum;
          end
          OUT: begin
            if (digest_ready) begin
              h_reg     <= H_INIT;
              count_reg <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: doc/sha_1_stream.md
Name: sha_1_stream

Overview:
- Parametrised SHA-1 block engine that is the next generation of the single-block SHA-1 accelerator.
- Processes multi-block messages: chaining values carry across 512-bit blocks, and the digest is emitted after the block flagged last.
- Uses a valid/ready handshake on the input and on the output, replacing start-edge detection and a one-cycle done pulse.
- Throughput is configurable by unrolling ROUNDS_PER_CYCLE compression rounds per clock. Sits between the host-side block loader and the digest consumer.

Parameters:
- ROUNDS_PER_CYCLE, 1: rounds per clock. Legal values: 1, 2, 4, 5, 8, 10, 16, 20, 40, 80 (must divide 80). Elaboration error otherwise.
- CNT_W, 16: width of the block counter.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- blk_valid  in  1  input block present
- blk_ready  out  1  engine can accept a block
- blk_first  in  1  load initial hash H0..H4 before this block
- blk_last  in  1  emit digest after this block
- blk_data  in  16x32 unpacked [15:0]  padded block; blk_data[0] = W0 (message bytes 0..3, big-endian)
- abort  in  1  synchronous flush of the current message
- digest_valid  out  1  digest available
- digest_ready  in  1  consumer accepts digest
- digest  out  5x32 unpacked [4:0]  digest[0] = H0 ... digest[4] = H4
- blk_count  out  CNT_W  blocks absorbed in the current message, saturating
- busy  out  1  state != IDLE

Behaviour:
- Async reset (reset_n low) clears state immediately:
  - State = IDLE; blk_ready = 0; digest_valid = 0; digest = 0; blk_count = 0; round counter = 0.
  - Chaining registers = 67452301, EFCDAB89, 98BADCFE, 10325476, C3D2E1F0.
  - blk_ready rises on the first rising edge after reset_n deasserts. Reset mid-round discards all work.
- States: IDLE, ROUND, UPDATE, OUT.
- IDLE:
  - blk_ready = 1.
  - On blk_valid & blk_ready (edge T):
    - Latch blk_data into the 16-word schedule window.
    - Load working a..e from the chaining registers, or from H0 constants if blk_first = 1.
    - If blk_first, the chaining registers are also reset to H0 and blk_count to 0.
    - Latch blk_last.
    - Go to ROUND; blk_ready drops at T+1.
- ROUND: lasts N = 80/ROUNDS_PER_CYCLE cycles (edges T+1..T+N). Each edge performs ROUNDS_PER_CYCLE sequential rounds t.
  - Schedule step: consume win[0]; shift in rotl1(win[13]^win[8]^win[2]^win[0]).
  - f and K by round range:
    - t 0-19: Ch(b,c,d), K = 5A827999
    - t 20-39: b^c^d, K = 6ED9EBA1
    - t 40-59: Maj(b,c,d), K = 8F1BBCDC
    - t 60-79: b^c^d, K = CA62C1D6
  - Update: temp = rotl5(a)+f+e+K+W (mod 2^32); e=d; d=c; c=rotl30(b); b=a; a=temp.
  - Round counter width is clog2(N), minimum 1; exit after the last step.
- UPDATE (edge T+N+1):
  - Chaining Hi += a..e (mod 2^32).
  - blk_count increments, saturating at 2^CNT_W-1.
  - If latched last: digest <= new H, digest_valid = 1, go to OUT. Otherwise go to IDLE (blk_ready = 1 from T+N+2).
- OUT:
  - digest and digest_valid are held stable while digest_ready = 0. blk_ready = 0.
  - On digest_valid & digest_ready: digest_valid = 0, chaining registers reset to H0, blk_count = 0, go to IDLE.
  - digest retains its value until the next last-block UPDATE.
- Latency: accept edge to digest_valid high = N+1 edges. Per-block occupancy = N+2 cycles, including the IDLE cycle; with ROUNDS_PER_CYCLE=1 that is 82.
- abort:
  - Sampled every edge, in any state, with priority over all other transitions.
  - Next state IDLE; digest_valid = 0; chaining registers = H0; blk_count = 0; digest unchanged.
  - A block offered in the same cycle as abort is not accepted.
- blk_valid while blk_ready = 0 is ignored; the source must hold the block.
- blk_data is sampled only at the accept edge.
- Absent blk_first, a block chains from the current registers. These equal H0 after reset, after a digest handshake, or after abort, so blk_first=0 on a message's first block is legal.
- digest_ready while digest_valid = 0 is ignored.
- blk_first and blk_last may both be 1 (single-block message).

Test Plan:
- "abc": one block, W0=61626380, W1..W14=0, W15=00000018, first=last=1 → digest a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d. digest_valid at accept+N+1 edges; check with ROUNDS_PER_CYCLE = 1, 4 and 80.
- Empty message: W0=80000000, others 0 → da39a3ee 5e6b4b0d 3255bfef 95601890 afd80709.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (first on block 1, last on block 2), with blk_valid low 5 cycles between blocks → 84983e44 1c3bd26e baae4aa1 f95129e5 e54670f1; blk_count=2 at digest_valid.
- Backpressure: hold digest_ready low 20 cycles after the "abc" digest → digest stable, blk_ready=0, busy=1; a blk_valid pulse during this time is not accepted. Release → blk_ready=1 next cycle; a following "abc" reproduces the same digest.
- abort at round 30 of block 1 of the two-block message, then "abc" sent with blk_first=0 → correct "abc" digest, blk_count=1.
- reset_n low for 1 cycle mid-ROUND → outputs at reset values immediately; blk_ready=1 one edge after release; subsequent empty-message digest correct.
